// File: rtl/pkt_rx_if.sv
// pkt_rx_if: byte-stream input, committed-payload output and the
// statistics counters of the packet receiver, grouped as one bundle.
// The master side drives the stream and the output back-pressure;
// the slave side is the receiver itself.
interface pkt_rx_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [15:0] pkt_ok_cnt;
  logic [15:0] pkt_err_cnt;
  logic [15:0] drop_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last,
    input  pkt_ok_cnt, pkt_err_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last,
    output pkt_ok_cnt, pkt_err_cnt, drop_cnt
  );
endinterface

// File: rtl/pkt_rx.sv
// pkt_rx: byte-serial packet receiver. Parses {addr,len} headers,
// keeps payload for its own PORT_ID in a commit/rollback FIFO so only
// complete (and, optionally, parity-checked) packets become visible,
// and counts good, errored and dropped packets with saturation.
// Optional feature macro: PKT_RX_PARITY_EN adds a trailing parity byte
// (XOR of header and payload) to every frame and a PARITY state.
module pkt_rx #(
  parameter logic [3:0] PORT_ID    = 4'h0,
  parameter int         FIFO_DEPTH = 16
) (
  input logic     clk,
  input logic     reset,
  pkt_rx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
`ifdef PKT_RX_PARITY_EN
  localparam logic [4:0] TRAIL = 5'd1;
`else
  localparam logic [4:0] TRAIL = 5'd0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
`ifdef PKT_RX_PARITY_EN
    S_PARITY  = 2'd2,
`endif
    S_DROP    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]     ok_cnt_q, err_cnt_q, drop_cnt_q;
  logic [8:0]      mem [FIFO_DEPTH];
`ifdef PKT_RX_PARITY_EN
  logic [7:0]      par_q;
`endif

  logic            in_ready_c;
  logic            accept;
  logic            full;
  logic            pop;
  logic            out_valid_c;
  logic [8:0]      rd_word;
  logic [3:0]      hdr_len;
  logic [3:0]      hdr_addr;
  logic            wr_en;
  logic            wr_last;
  logic            commit_now;
  logic            rollback_now;
  logic            inc_ok;
  logic            inc_err;
  logic            inc_drop;

  // Saturating +1 for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  assign hdr_len  = bus.in_data[3:0];
  assign hdr_addr = bus.in_data[7:4];

  // Only payload writes can be blocked; every other state always takes a byte.
  assign full       = ((wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH));
  assign in_ready_c = (state_q == S_PAYLOAD) ? !full : 1'b1;
  assign accept     = bus.in_valid & in_ready_c;

  // Read side only ever sees committed entries.
  assign out_valid_c = (rd_ptr_q != commit_ptr_q);
  assign pop         = out_valid_c & bus.out_ready;
  assign rd_word     = mem[rd_ptr_q[AW-1:0]];
  assign wr_last     = (cnt_q == 5'd1);

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_data    = out_valid_c ? rd_word[7:0] : 8'h00;
  assign bus.out_last    = out_valid_c ? rd_word[8]   : 1'b0;
  assign bus.pkt_ok_cnt  = ok_cnt_q;
  assign bus.pkt_err_cnt = err_cnt_q;
  assign bus.drop_cnt    = drop_cnt_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state decode from the accepted byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (hdr_len != 4'd0))
          state_d = (hdr_addr == PORT_ID) ? S_PAYLOAD : S_DROP;
      end
      S_PAYLOAD: begin
        if (accept && wr_last) begin
`ifdef PKT_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef PKT_RX_PARITY_EN
      S_PARITY: begin
        if (accept) state_d = S_IDLE;
      end
`endif
      S_DROP: begin
        if (accept && (cnt_q == 5'd1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: FIFO write/commit/rollback strobes and counter events.
  always_comb begin
    wr_en        = 1'b0;
    commit_now   = 1'b0;
    rollback_now = 1'b0;
    inc_ok       = 1'b0;
    inc_err      = 1'b0;
    inc_drop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          inc_err  = (hdr_len == 4'd0);
          inc_drop = (hdr_len != 4'd0) && (hdr_addr != PORT_ID);
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          wr_en = 1'b1;
`ifndef PKT_RX_PARITY_EN
          if (wr_last) begin
            commit_now = 1'b1;
            inc_ok     = 1'b1;
          end
`endif
        end
      end
`ifdef PKT_RX_PARITY_EN
      S_PARITY: begin
        if (accept) begin
          if (bus.in_data == par_q) begin
            commit_now = 1'b1;
            inc_ok     = 1'b1;
          end else begin
            rollback_now = 1'b1;
            inc_err      = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Byte counter and FIFO pointer next-state. Rollback returns to the
  // commit point, which can never be behind the read pointer.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      case (state_q)
        S_IDLE:    cnt_d = {1'b0, hdr_len} + ((hdr_addr != PORT_ID) ? TRAIL : 5'd0);
        S_PAYLOAD: cnt_d = cnt_q - 5'd1;
        S_DROP:    cnt_d = cnt_q - 5'd1;
        default:   cnt_d = cnt_q;
      endcase
    end
    wr_ptr_d     = rollback_now ? commit_ptr_q : (wr_ptr_q + PW'(wr_en));
    commit_ptr_d = commit_now ? wr_ptr_d : commit_ptr_q;
    rd_ptr_d     = rd_ptr_q + PW'(pop);
  end

  // Control registers: counters, pointers and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      ok_cnt_q     <= '0;
      err_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ok_cnt_q     <= sat_inc(ok_cnt_q, inc_ok);
      err_cnt_q    <= sat_inc(err_cnt_q, inc_err);
      drop_cnt_q   <= sat_inc(drop_cnt_q, inc_drop);
    end
  end

  // Payload storage: data byte plus end-of-packet flag.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {wr_last, bus.in_data};
  end

`ifdef PKT_RX_PARITY_EN
  // Running XOR of header and payload for the trailing parity check.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state_q == S_IDLE)         par_q <= bus.in_data;
      else if (state_q == S_PAYLOAD) par_q <= par_q ^ bus.in_data;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rx.sv
// Self-checking bench for pkt_rx: directed scenarios plus randomized
// frames, compared against a frame-level reference model.
module tb_pkt_rx;
  localparam logic [3:0] PORT = 4'h3;
`ifdef PKT_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  pkt_rx_if bus();

  pkt_rx #(.PORT_ID(PORT), .FIFO_DEPTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  logic [15:0] m_ok, m_err, m_drop;
  logic [7:0]  empty_pl[$];

  // Collect every popped output byte.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_last, bus.out_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] frame_xor(input logic [7:0] hdr, input logic [7:0] pl[$]);
    logic [7:0] x;
    x = hdr;
    foreach (pl[i]) x = x ^ pl[i];
    return x;
  endfunction

  // Frame-level reference: decide the fate of a whole frame.
  function automatic void model_frame(input logic [7:0] hdr, input logic [7:0] pl[$],
                                      input logic [7:0] par);
    if (hdr[3:0] == 4'd0) m_err = sat16(m_err);
    else if (hdr[7:4] != PORT) m_drop = sat16(m_drop);
    else if (PAR_ON && (par != frame_xor(hdr, pl))) m_err = sat16(m_err);
    else begin
      m_ok = sat16(m_ok);
      foreach (pl[i]) exp_q.push_back({(i == pl.size() - 1), pl[i]});
    end
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=%0b want=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] pl[$], input logic [7:0] par);
    model_frame(hdr, pl, par);
    drive_byte(hdr);
    if (hdr[3:0] != 4'd0) begin
      foreach (pl[i]) drive_byte(pl[i]);
      if (PAR_ON) drive_byte(par);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    m_ok = 0; m_err = 0; m_drop = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h want=00", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%0b want=0", bus.out_last); end
    checks++; if (bus.pkt_ok_cnt !== 16'd0) begin errors++; $display("FAIL rst_ok got=%0d want=0", bus.pkt_ok_cnt); end
    checks++; if (bus.pkt_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err got=%0d want=0", bus.pkt_err_cnt); end
    checks++; if (bus.drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop got=%0d want=0", bus.drop_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] pl[$];
    bus.out_ready = 1'b0;
    pl = '{8'h7E};
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_pre_valid got=%0b want=0", bus.out_valid); end
    send_frame(8'h31, pl, frame_xor(8'h31, pl));
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%0b want=1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h7E) begin errors++; $display("FAIL lat_data got=%h want=7e", bus.out_data); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL lat_last got=%0b want=1", bus.out_last); end
    checks++; if (bus.pkt_ok_cnt !== m_ok) begin errors++; $display("FAIL lat_ok got=%0d want=%0d", bus.pkt_ok_cnt, m_ok); end
    bus.out_ready = 1'b1;
    pl = '{8'hAA, 8'h55};
    send_frame(8'h32, pl, frame_xor(8'h32, pl));
    wait_drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus.pkt_ok_cnt !== m_ok) begin errors++; $display("FAIL basic_ok got=%0d want=%0d", bus.pkt_ok_cnt, m_ok); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity_err();
`ifdef PKT_RX_PARITY_EN
    logic [7:0] pl[$];
    bus.out_ready = 1'b1;
    pl = '{8'hAA, 8'h55};
    send_frame(8'h32, pl, frame_xor(8'h32, pl) ^ 8'hCC);
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL par_valid got=%0b want=0", bus.out_valid); end
    checks++; if (bus.pkt_err_cnt !== m_err) begin errors++; $display("FAIL par_err got=%0d want=%0d", bus.pkt_err_cnt, m_err); end
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h33, pl, frame_xor(8'h33, pl));
    wait_drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL par_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL par_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus.pkt_ok_cnt !== m_ok) begin errors++; $display("FAIL par_ok got=%0d want=%0d", bus.pkt_ok_cnt, m_ok); end
    got_q.delete(); exp_q.delete();
`endif
  endtask

  task automatic test_drop();
    logic [7:0] pl[$];
    bus.out_ready = 1'b1;
    pl = '{8'h01, 8'h02};
    send_frame(8'h52, pl, frame_xor(8'h52, pl));
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got=%0b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got=%0b want=0", bus.out_valid); end
    checks++; if (bus.drop_cnt !== m_drop) begin errors++; $display("FAIL drop_cnt got=%0d want=%0d", bus.drop_cnt, m_drop); end
    pl = '{8'h99};
    send_frame(8'h31, pl, frame_xor(8'h31, pl));
    wait_drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL drop_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_len0();
    bus.out_ready = 1'b1;
    send_frame(8'h30, empty_pl, 8'h30);
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.pkt_err_cnt !== m_err) begin errors++; $display("FAIL len0_err got=%0d want=%0d", bus.pkt_err_cnt, m_err); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL len0_valid got=%0b want=0", bus.out_valid); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL len0_nowrite got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_stall();
    logic [7:0] a[$];
    logic [7:0] b[$];
    for (int i = 0; i < 15; i++) begin
      a.push_back(8'($urandom));
      b.push_back(8'($urandom));
    end
    bus.out_ready = 1'b0;
    send_frame(8'h3F, a, frame_xor(8'h3F, a));
    model_frame(8'h3F, b, frame_xor(8'h3F, b));
    drive_byte(8'h3F);
    drive_byte(b[0]);
    bus.in_valid = 1'b1;
    bus.in_data  = b[1];
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%0b want=0", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 1; i < 15; i++) drive_byte(b[i]);
    if (PAR_ON) drive_byte(frame_xor(8'h3F, b));
    bus.in_valid = 1'b0;
    wait_drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus.pkt_ok_cnt !== m_ok) begin errors++; $display("FAIL stall_ok got=%0d want=%0d", bus.pkt_ok_cnt, m_ok); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl[$];
    bus.out_ready = 1'b0;
    pl = '{8'hA1, 8'hA2};
    send_frame(8'h32, pl, frame_xor(8'h32, pl));
    drive_byte(8'h38);
    drive_byte(8'hB1);
    drive_byte(8'hB2);
    drive_byte(8'hB3);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%0b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL mid_data got=%h want=00", bus.out_data); end
    checks++; if (bus.pkt_ok_cnt !== 16'd0) begin errors++; $display("FAIL mid_ok got=%0d want=0", bus.pkt_ok_cnt); end
    exp_q.delete(); got_q.delete();
    m_ok = 0; m_err = 0; m_drop = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    pl = '{8'hC1, 8'hC2, 8'hC3};
    send_frame(8'h33, pl, frame_xor(8'h33, pl));
    wait_drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus.pkt_ok_cnt !== m_ok) begin errors++; $display("FAIL mid_ok2 got=%0d want=%0d", bus.pkt_ok_cnt, m_ok); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          logic [7:0] pl[$];
          logic [3:0] addr, len;
          logic [7:0] hdr, par;
          addr = ($urandom_range(0, 9) < 7) ? PORT : 4'($urandom_range(0, 15));
          len  = 4'($urandom_range(0, 15));
          hdr  = {addr, len};
          pl.delete();
          for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
          par = frame_xor(hdr, pl) ^ (($urandom_range(0, 4) == 0) ? 8'h01 : 8'h00);
          send_frame(hdr, pl, par);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus.pkt_ok_cnt !== m_ok) begin errors++; $display("FAIL rnd_ok got=%0d want=%0d", bus.pkt_ok_cnt, m_ok); end
    checks++; if (bus.pkt_err_cnt !== m_err) begin errors++; $display("FAIL rnd_err got=%0d want=%0d", bus.pkt_err_cnt, m_err); end
    checks++; if (bus.drop_cnt !== m_drop) begin errors++; $display("FAIL rnd_drop got=%0d want=%0d", bus.drop_cnt, m_drop); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_drop();
    test_len0();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
